cpuif_ram_target: RTL and testbench

// - Memory-side responder for the CPU bus interface request/data stream: consumes req_*/dout, produces din/din_ack handshake.
// - Serves single-beat (byte/word/long) and 4-beat line transfers from on-chip byte-writable block RAM; sits directly behind cpuif.
// - Big-endian lane order; line bursts wrap within the 16-byte line.

---
 rtl/cpuif_pkg.sv | 36 +++
 rtl/cpuif_ram_target_if.sv | 28 ++
 rtl/cpuif_ram_target_bram_be.sv | 26 ++
 rtl/cpuif_ram_target.sv | 129 ++++++++++++
 tb/tb_cpuif_ram_target.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/cpuif_pkg.sv
// Shared definitions for the CPU bus interface and its memory-side target:
// burst lengths, transfer size/type codes, target FSM states and byte-lane mapping.
package cpuif_pkg;

    localparam logic [2:0] LEN_SINGLE = 3'd1;
    localparam logic [2:0] LEN_LINE   = 3'd4;

    localparam logic [1:0] SIZ_LONG = 2'b00;
    localparam logic [1:0] SIZ_BYTE = 2'b01;
    localparam logic [1:0] SIZ_WORD = 2'b10;
    localparam logic [1:0] SIZ_LINE = 2'b11;

    localparam logic [1:0] TT_NORMAL      = 2'b00;
    localparam logic [1:0] TT_MOVE16      = 2'b01;
    localparam logic [1:0] TT_ALTERNATE   = 2'b10;
    localparam logic [1:0] TT_ACKNOWLEDGE = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD_FETCH,
        RD_LOAD,
        RD_HOLD,
        WR_DATA
    } state_t;

    // Big-endian lanes: mask bit3 is byte offset 0, which lives in [31:24].
    function automatic logic [31:0] lane_mask(input logic [3:0] mask);
        logic [31:0] bits;
        bits = '0;
        for (int i = 0; i < 4; i++) begin
            bits[8*i +: 8] = {8{mask[i]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/cpuif_ram_target_if.sv
// Request / write-data / read-data handshake between cpuif and the RAM target.
interface cpuif_ram_target_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_len;
    logic [3:0]  req_mask;
    logic [31:0] req_addr;
    logic        req_we;
    logic        dout_valid;
    logic [31:0] dout;
    logic        din_valid;
    logic [31:0] din;
    logic        din_ack;

    modport master (
        output req_valid, req_len, req_mask, req_addr, req_we,
        output dout_valid, dout, din_ack,
        input  req_ready, din_valid, din
    );

    modport slave (
        input  req_valid, req_len, req_mask, req_addr, req_we,
        input  dout_valid, dout, din_ack,
        output req_ready, din_valid, din
    );

endinterface

// File: rtl/cpuif_ram_target_bram_be.sv
// Single-port block RAM, 32-bit words with per-byte write enables and a
// registered read port (read-before-write). Contents are never reset.
module bram_be
   import cpuif_pkg::*;
#(
   parameter int MEM_AW    = 12,
   parameter     INIT_FILE = ""
) (
   input  logic              clk,
   input  logic [MEM_AW-1:0] addr,
   input  logic [3:0]        we,
   input  logic [31:0]       wdata,
   output logic [31:0]       q
);

   logic [31:0] mem [2**MEM_AW];

   // Byte-merged write and one-cycle registered read of the same word.
   always_ff @(posedge clk) begin
      if (|we) begin
         mem[addr] <= (mem[addr] & ~lane_mask(we)) | (wdata & lane_mask(we));
      end
      q <= mem[addr];
   end

endmodule

// File: rtl/cpuif_ram_target.sv
// Memory-side responder for cpuif: serves single and wrapping line transfers
// from byte-writable block RAM using the req/dout/din handshake.
module cpuif_ram_target
    import cpuif_pkg::*;
#(
    parameter int MEM_AW    = 12,
    parameter     INIT_FILE = ""
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    cpuif_ram_target_if.slave   bus,
    output logic                ovf_o
);

    state_t            state;
    state_t            state_next;
    logic [MEM_AW-1:0] w0;
    logic [2:0]        len;
    logic [3:0]        mask;
    logic [2:0]        beat;
    logic [31:0]       din_reg;
    logic              din_valid_reg;
    logic              ready_en;
    logic [3:0]        ram_we;
    logic [31:0]       ram_q;
    logic [MEM_AW-1:0] beat_addr;
    logic              last_beat;

    // Beats wrap modulo 4 inside the 16-byte line, even for lengths above 4.
    assign beat_addr = {w0[MEM_AW-1:2], w0[1:0] + beat[1:0]};
    assign last_beat = (beat + 3'd1) == len;

    assign bus.req_ready = ready_en && (state == IDLE || state == WR_DATA);
    assign bus.din_valid = din_valid_reg;
    assign bus.din       = din_reg;

    bram_be #(
        .MEM_AW    (MEM_AW),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk_i),
        .addr  (beat_addr),
        .we    (ram_we),
        .wdata (bus.dout),
        .q     (ram_q)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and RAM byte-write strobes.
    always_comb begin
        state_next = state;
        ram_we     = 4'b0000;
        case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    state_next = bus.req_we ? WR_DATA : RD_FETCH;
                end
            end
            RD_FETCH: state_next = RD_LOAD;
            RD_LOAD:  state_next = RD_HOLD;
            RD_HOLD: begin
                if (bus.din_ack) begin
                    state_next = last_beat ? IDLE : RD_FETCH;
                end
            end
            WR_DATA: begin
                if (bus.dout_valid) begin
                    ram_we     = mask;
                    state_next = last_beat ? IDLE : WR_DATA;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, beat counter, read-data register and sticky overflow flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w0            <= '0;
            len           <= LEN_SINGLE;
            mask          <= 4'b0000;
            beat          <= 3'd0;
            din_reg       <= 32'd0;
            din_valid_reg <= 1'b0;
            ready_en      <= 1'b0;
            ovf_o         <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (bus.req_valid && state != IDLE) begin
                ovf_o <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        w0   <= bus.req_addr[MEM_AW+1:2];
                        len  <= (bus.req_len == 3'd0) ? LEN_SINGLE : bus.req_len;
                        mask <= bus.req_mask;
                        beat <= 3'd0;
                    end
                end
                RD_LOAD: begin
                    din_reg       <= ram_q;
                    din_valid_reg <= 1'b1;
                end
                RD_HOLD: begin
                    if (bus.din_ack) begin
                        din_valid_reg <= 1'b0;
                        beat          <= beat + 3'd1;
                    end
                end
                WR_DATA: begin
                    if (bus.dout_valid) begin
                        beat <= beat + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpuif_ram_target.sv
// Scoreboard bench for cpuif_ram_target: a byte-lane memory model predicts
// read data, which is queued at request time and compared as beats arrive.
module tb_cpuif_ram_target;

    import cpuif_pkg::*;

    logic        clock = 1'b0;
    logic        rstN;
    logic        ovf;
    int          checkCount = 0;
    int          failCount  = 0;
    logic [31:0] expQ[$];
    logic [31:0] model[int];

    cpuif_ram_target_if bus();

    cpuif_ram_target #(
        .MEM_AW    (12),
        .INIT_FILE ("")
    ) dut (
        .clk_i  (clock),
        .rst_ni (rstN),
        .bus    (bus),
        .ovf_o  (ovf)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic int beatWord(input int w0, input int b);
        return (w0 & ~3) | ((w0 + b) & 3);
    endfunction

    function automatic logic [31:0] modelRead(input int wi);
        if (model.exists(wi)) return model[wi];
        return 32'h0;
    endfunction

    task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] len,
                                 input logic [3:0] mask, input logic we);
        @(posedge clock); #1;
        bus.req_addr  = addr;
        bus.req_len   = len;
        bus.req_mask  = mask;
        bus.req_we    = we;
        bus.req_valid = 1'b1;
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic waitValid(output int edges);
        edges = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock); #1;
            if (bus.din_valid) begin
                edges = i;
                return;
            end
        end
    endtask

    task automatic writeTransfer(input logic [31:0] addr, input logic [2:0] len,
                                 input logic [3:0] mask, input logic [127:0] beats);
        int n;
        int w0;
        int wi;
        logic [31:0] d;
        logic [31:0] lm;
        applyStimulus(addr, len, mask, 1'b1);
        n  = (len == 3'd0) ? 1 : int'(len);
        w0 = int'((addr >> 2) & 32'hFFF);
        for (int b = 0; b < n; b++) begin
            d = beats[127 - 32*(b % 4) -: 32];
            bus.dout       = d;
            bus.dout_valid = 1'b1;
            @(posedge clock); #1;
            bus.dout_valid = 1'b0;
            lm = '0;
            for (int i = 0; i < 4; i++) if (mask[i]) lm[8*i +: 8] = 8'hFF;
            wi = beatWord(w0, b);
            model[wi] = (modelRead(wi) & ~lm) | (d & lm);
        end
        checkOutput("wr_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    endtask

    task automatic readTransfer(input logic [31:0] addr, input logic [2:0] len, input int ovfBeat);
        int n;
        int w0;
        int k;
        logic [31:0] exp;
        applyStimulus(addr, len, 4'b0000, 1'b0);
        n  = (len == 3'd0) ? 1 : int'(len);
        w0 = int'((addr >> 2) & 32'hFFF);
        for (int b = 0; b < n; b++) expQ.push_back(modelRead(beatWord(w0, b)));
        for (int b = 0; b < n; b++) begin
            waitValid(k);
            if (k < 0) begin
                checkOutput("rd_timeout", 32'd0, 32'd1);
                expQ.delete();
                return;
            end
            checkOutput("rd_latency", k, 32'd2);
            exp = expQ.pop_front();
            checkOutput("rd_data", bus.din, exp);
            if (b == ovfBeat) begin
                bus.req_addr  = 32'h200;
                bus.req_we    = 1'b1;
                bus.req_valid = 1'b1;
                @(posedge clock); #1;
                bus.req_valid = 1'b0;
                bus.req_we    = 1'b0;
                checkOutput("ovf_set", {31'd0, ovf}, 32'd1);
                checkOutput("hold_valid", {31'd0, bus.din_valid}, 32'd1);
                checkOutput("hold_data", bus.din, exp);
            end
            bus.din_ack = 1'b1;
            @(posedge clock); #1;
            bus.din_ack = 1'b0;
            checkOutput("valid_drop", {31'd0, bus.din_valid}, 32'd0);
        end
        checkOutput("rd_idle_ready", {31'd0, bus.req_ready}, 32'd1);
        checkOutput("sb_empty", expQ.size(), 32'd0);
    endtask

    // Main sequence: reset, single/byte/word/line transfers, overflow, stray strobes, mid-burst reset.
    initial begin
        int k;
        bus.req_valid  = 1'b0;
        bus.req_len    = 3'd0;
        bus.req_mask   = 4'b0000;
        bus.req_addr   = 32'h0;
        bus.req_we     = 1'b0;
        bus.dout_valid = 1'b0;
        bus.dout       = 32'h0;
        bus.din_ack    = 1'b0;
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #1;
        checkOutput("rst_ready", {31'd0, bus.req_ready}, 32'd0);
        checkOutput("rst_din_valid", {31'd0, bus.din_valid}, 32'd0);
        checkOutput("rst_din", bus.din, 32'd0);
        checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
        #20 rstN = 1'b1;
        #1 checkOutput("rel_ready_before_edge", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clock); #1;
        checkOutput("rel_ready_after_edge", {31'd0, bus.req_ready}, 32'd1);

        writeTransfer(32'h10, LEN_SINGLE, 4'b1111, {32'hDEADBEEF, 96'd0});
        readTransfer(32'h10, LEN_SINGLE, -1);
        writeTransfer(32'h11, LEN_SINGLE, 4'b0100, {32'h00AB0000, 96'd0});
        readTransfer(32'h10, LEN_SINGLE, -1);
        writeTransfer(32'h12, LEN_SINGLE, 4'b0011, {32'h00001234, 96'd0});
        readTransfer(32'h10, 3'd0, -1);
        checkOutput("ovf_clear_so_far", {31'd0, ovf}, 32'd0);

        writeTransfer(32'h100, LEN_LINE, 4'b1111,
                      {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444});
        readTransfer(32'h108, LEN_LINE, 1);
        readTransfer(32'h100, 3'd6, -1);
        checkOutput("ovf_sticky", {31'd0, ovf}, 32'd1);

        @(posedge clock); #1;
        bus.dout        = 32'hFFFFFFFF;
        bus.dout_valid  = 1'b1;
        bus.din_ack     = 1'b1;
        @(posedge clock); #1;
        bus.dout_valid  = 1'b0;
        bus.din_ack     = 1'b0;
        checkOutput("stray_ready", {31'd0, bus.req_ready}, 32'd1);
        checkOutput("stray_din_valid", {31'd0, bus.din_valid}, 32'd0);
        checkOutput("stray_ovf", {31'd0, ovf}, 32'd1);
        readTransfer(32'h100, LEN_LINE, -1);

        applyStimulus(32'h104, LEN_SINGLE, 4'b0000, 1'b0);
        waitValid(k);
        checkOutput("pre_reset_valid", {31'd0, bus.din_valid}, 32'd1);
        rstN = 1'b0;
        #2;
        checkOutput("midrst_din_valid", {31'd0, bus.din_valid}, 32'd0);
        checkOutput("midrst_ready", {31'd0, bus.req_ready}, 32'd0);
        checkOutput("midrst_ovf", {31'd0, ovf}, 32'd0);
        #2 rstN = 1'b1;
        #1 checkOutput("midrst_ready_before_edge", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clock); #1;
        checkOutput("midrst_ready_after_edge", {31'd0, bus.req_ready}, 32'd1);
        readTransfer(32'h100, LEN_LINE, -1);
        readTransfer(32'h10, LEN_SINGLE, -1);
        checkOutput("final_ovf", {31'd0, ovf}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

    // Global watchdog so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
